// File: rtl/band_eq_mixer.sv
// Per-band gain and mixing stage: snapshots NUM_BANDS samples on a strobe, then
// multiply-accumulates them serially with one multiplier and emits a saturated sum.
module band_eq_mixer #(
  parameter int unsigned NUM_BANDS = 10,
  parameter int unsigned GAIN_W    = 8,
  parameter int unsigned GAIN_FRAC = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NUM_BANDS*16-1:0]       band_data,
  input  logic [NUM_BANDS*GAIN_W-1:0]   gain,
  output logic [15:0]                   data_out,
  output logic                          valid_out,
  output logic                          clip,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned ProdW = 16 + GAIN_W + 1;
  localparam int unsigned AccW  = ProdW + $clog2(NUM_BANDS);
  localparam int unsigned IdxW  = $clog2(NUM_BANDS);

  localparam logic signed [AccW-1:0] SatMax = AccW'(32767);
  localparam logic signed [AccW-1:0] SatMin = AccW'(-32768);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                  state_q, state_d;
  logic signed [AccW-1:0]  acc_q, acc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic signed [15:0]      samp_q [NUM_BANDS];
  logic [GAIN_W-1:0]       gain_q [NUM_BANDS];
  logic [15:0]             data_out_q, data_out_d;
  logic                    valid_q, valid_d;
  logic                    clip_q, clip_d;
  logic                    overrun_q, overrun_d;
  logic                    load;

  logic signed [15:0]      cur_sample;
  logic [GAIN_W-1:0]       cur_gain;
  logic signed [ProdW-1:0] prod;
  logic signed [AccW-1:0]  shifted;

  assign cur_sample = samp_q[idx_q];
  assign cur_gain   = gain_q[idx_q];
  // Gain is zero-extended so the full unsigned range multiplies as positive.
  assign prod       = ProdW'(cur_sample) * ProdW'($signed({1'b0, cur_gain}));
  assign shifted    = acc_q >>> GAIN_FRAC;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    data_out_d = data_out_q;
    clip_d     = clip_q;
    valid_d    = 1'b0;
    overrun_d  = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        overrun_d = in_valid;
        acc_d     = acc_q + AccW'(prod);
        idx_d     = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_BANDS - 1)) state_d = StDone;
      end
      StDone: begin
        overrun_d = in_valid;
        valid_d   = 1'b1;
        state_d   = StIdle;
        if (shifted > SatMax) begin
          data_out_d = 16'h7fff;
          clip_d     = 1'b1;
        end else if (shifted < SatMin) begin
          data_out_d = 16'h8000;
          clip_d     = 1'b1;
        end else begin
          data_out_d = shifted[15:0];
          clip_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      idx_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        samp_q[i] <= '0;
        gain_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
      overrun_q  <= overrun_d;
      if (load) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          samp_q[i] <= band_data[16*i +: 16];
          gain_q[i] <= gain[GAIN_W*i +: GAIN_W];
        end
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_band_eq_mixer.sv
// Directed bench for band_eq_mixer: table of single-mix vectors plus
// hand-written overrun, back-to-back and mid-mix reset sequences.
module tb_band_eq_mixer;

  localparam int NB = 10;
  localparam int GW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [NB*16-1:0]   band_data;
  logic [NB*GW-1:0]   gain;
  logic [15:0]        data_out;
  logic               valid_out;
  logic               clip;
  logic               busy;
  logic               overrun;

  int n_checks = 0;
  int n_errors = 0;

  band_eq_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .band_data (band_data),
    .gain      (gain),
    .data_out  (data_out),
    .valid_out (valid_out),
    .clip      (clip),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [NB*16-1:0] data;
    logic [NB*GW-1:0] gains;
    int             exp_data;
    bit             exp_clip;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB*16-1:0] all_bands(input int v);
    logic [NB*16-1:0] r;
    for (int i = 0; i < NB; i++) r[16*i +: 16] = 16'(v);
    return r;
  endfunction

  function automatic logic [NB*GW-1:0] all_gains(input int g);
    logic [NB*GW-1:0] r;
    for (int i = 0; i < NB; i++) r[GW*i +: GW] = GW'(g);
    return r;
  endfunction

  // Strobe once, then check latency, width, value, clip, busy and absence of overrun.
  task automatic run_vec(input string nm, input logic [NB*16-1:0] d,
                         input logic [NB*GW-1:0] g, input int exp_d, input bit exp_c);
    int lat;
    int ov;
    band_data = d;
    gain      = g;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    ov  = 0;
    check({nm, " busy_rise"}, int'(busy), 1);
    while (!valid_out && lat < 40) begin
      if (overrun) ov++;
      tick();
      lat++;
    end
    check({nm, " latency"}, lat, 12);
    check({nm, " data"}, int'($signed(data_out)), exp_d);
    check({nm, " clip"}, int'(clip), int'(exp_c));
    check({nm, " busy_fall"}, int'(busy), 0);
    check({nm, " overrun"}, ov, 0);
    tick();
    check({nm, " valid_width"}, int'(valid_out), 0);
    check({nm, " data_hold"}, int'($signed(data_out)), exp_d);
  endtask

  initial begin
    int lat, ov_cnt, v_cnt, v_lat, v_dat;

    for (int i = 0; i < 7; i++) begin
      vecs[i].data  = '0;
      vecs[i].gains = all_gains(64);
    end
    vecs[0].name = "unity_single";
    vecs[0].data[15:0] = 16'(1000);
    vecs[0].exp_data = 1000;   vecs[0].exp_clip = 1'b0;

    vecs[1].name  = "weighted";
    for (int i = 0; i < NB; i++) vecs[1].data[16*i +: 16] = 16'(100 * i);
    vecs[1].gains = all_gains(32);
    vecs[1].exp_data = 2250;   vecs[1].exp_clip = 1'b0;

    vecs[2].name  = "floor_neg";
    vecs[2].data[15:0] = 16'(-1);
    vecs[2].gains = all_gains(32);
    vecs[2].exp_data = -1;     vecs[2].exp_clip = 1'b0;

    vecs[3].name  = "sat_pos";
    vecs[3].data  = all_bands(10000);
    vecs[3].exp_data = 32767;  vecs[3].exp_clip = 1'b1;

    vecs[4].name  = "sat_neg";
    vecs[4].data  = all_bands(-10000);
    vecs[4].exp_data = -32768; vecs[4].exp_clip = 1'b1;

    vecs[5].name  = "zero";
    vecs[5].exp_data = 0;      vecs[5].exp_clip = 1'b0;

    // 1000*0 + (-2000)*255 + 300*128 = -471600; /64 = -7368.75 -> floor -7369
    vecs[6].name  = "mixed_gain";
    vecs[6].data[15:0]  = 16'(1000);
    vecs[6].data[31:16] = 16'(-2000);
    vecs[6].data[47:32] = 16'(300);
    vecs[6].gains = '0;
    vecs[6].gains[7:0]   = 8'd0;
    vecs[6].gains[15:8]  = 8'd255;
    vecs[6].gains[23:16] = 8'd128;
    vecs[6].exp_data = -7369;  vecs[6].exp_clip = 1'b0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    band_data = '0;
    gain      = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset data_out", int'(data_out), 0);
    check("reset valid_out", int'(valid_out), 0);
    check("reset clip", int'(clip), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i].name, vecs[i].data, vecs[i].gains, vecs[i].exp_data, vecs[i].exp_clip);

    // Overrun with input snapshot: inputs change right after the accepted strobe.
    band_data = '0;
    band_data[15:0] = 16'(500);
    gain     = all_gains(64);
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    band_data = all_bands(7777);
    lat = 1; ov_cnt = 0; v_cnt = 0; v_lat = 0; v_dat = 0;
    while (lat < 30) begin
      if (overrun) ov_cnt++;
      if (valid_out) begin
        v_cnt++;
        v_lat = lat;
        v_dat = int'($signed(data_out));
      end
      in_valid = (lat == 5);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("overrun pulses", ov_cnt, 1);
    check("overrun valid count", v_cnt, 1);
    check("overrun latency", v_lat, 12);
    check("overrun data", v_dat, 500);

    // Back-to-back: second strobe in the valid_out cycle is accepted.
    band_data = '0;
    band_data[15:0] = 16'(1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!valid_out && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b first latency", lat, 12);
    check("b2b first data", int'($signed(data_out)), 1000);
    band_data = '0;
    band_data[31:16] = 16'(-300);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; ov_cnt = 0;
    while (!valid_out && lat < 40) begin
      if (overrun) ov_cnt++;
      tick();
      lat++;
    end
    if (overrun) ov_cnt++;
    check("b2b second latency", lat, 12);
    check("b2b second data", int'($signed(data_out)), -300);
    check("b2b overrun", ov_cnt, 0);
    tick();

    // Mid-mix reset, preceded by a clipping mix so outputs are non-zero.
    run_vec("pre_reset", all_bands(-10000), all_gains(64), -32768, 1'b1);
    band_data = all_bands(1234);
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (lat < 4) begin
      tick();
      lat++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst data_out", int'(data_out), 0);
    check("rst valid_out", int'(valid_out), 0);
    check("rst clip", int'(clip), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    v_cnt = 0;
    repeat (20) begin
      if (valid_out) v_cnt++;
      tick();
    end
    check("rst aborted valid", v_cnt, 0);
    run_vec("post_reset", vecs[0].data, all_gains(64), 1000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/band_eq_mixer.md
# band_eq_mixer

Per-band gain and summing stage that sits directly downstream of the band playback modules. It snapshots one signed 16-bit sample from each of NUM_BANDS bands on a shared sample strobe, applies a per-band unsigned gain, and accumulates the products serially with a single multiplier. It outputs one saturated 16-bit mixed sample per strobe. The block runs on the 4.4 MHz system clock; the 44 kHz sample rate leaves about 100 cycles per sample, far more than the NUM_BANDS+2 cycles the block needs.

## Interface
- NUM_BANDS, 10, number of band inputs; must be at least 2.
- GAIN_W, 8, width of each unsigned gain field.
- GAIN_FRAC, 6, number of fractional gain bits; gain 2^GAIN_FRAC is unity (64 at default).
- clk  in  1  system clock (4.4 MHz); the block uses one clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  one-cycle strobe: all band samples are valid this cycle (driven by the playback valid_out).
- band_data  in  NUM_BANDS*16  signed samples; band i occupies bits [16*i+15:16*i].
- gain  in  NUM_BANDS*GAIN_W  unsigned gains; band i occupies bits [GAIN_W*i+GAIN_W-1:GAIN_W*i].
- data_out  out  16  signed mixed sample; holds its value between strobes.
- valid_out  out  1  one-cycle pulse when data_out updates.
- clip  out  1  updates together with valid_out; 1 when that sample saturated.
- busy  out  1  high while a mix is in progress.
- overrun  out  1  one-cycle pulse when in_valid arrives while busy.

## Operation
- The FSM has three states: IDLE, MAC and DONE. busy = (state != IDLE).
- IDLE with in_valid=1: register all band_data and gain fields into snapshot registers, clear the accumulator, set idx=0, go to MAC. Inputs may change after this cycle without affecting the result.
- MAC, once per cycle: acc += sample[idx] * $signed({1'b0, gain[idx]}); idx++. When idx == NUM_BANDS-1, go to DONE.
- DONE: data_out <= sat16(acc >>> GAIN_FRAC); clip <= (saturation occurred); valid_out <= 1; go to IDLE.
- Arithmetic:
  - Each product is 16+GAIN_W+1 bits, signed.
  - The accumulator is 16+GAIN_W+1+$clog2(NUM_BANDS) bits, so no internal overflow is possible.
  - The shift is arithmetic, which floors toward negative infinity; there is no rounding.
  - sat16 clamps to the range [-32768, 32767].
- in_valid in MAC or DONE: the strobe is ignored, overrun pulses for one cycle, and the in-flight mix completes unaffected.
- in_valid in the same cycle that valid_out is high is accepted, because the state is IDLE in that cycle.
- rst in any state: the block enters IDLE on the next edge. Every output and internal register is cleared and the in-flight mix is discarded; no valid_out is produced for it.

## Timing
- Reset values: data_out=0, valid_out=0, clip=0, busy=0, overrun=0, state=IDLE, acc=0, idx=0.
- Latency: in_valid is sampled at edge E0, and valid_out is high in the cycle after edge E0+NUM_BANDS+1. That is NUM_BANDS+2 clocks, or 12 at the default.
- busy rises in the cycle after E0 and falls in the same cycle valid_out rises.
- The minimum accepted strobe spacing is NUM_BANDS+2 cycles. The 100-cycle spacing of the 44 kHz strobe never overruns.
- All outputs are registered; there is no combinational path from input to output.
- data_out and clip hold their values until the next DONE or rst.

## Test plan
- Unity, single band: gains all 64, band0=1000, others 0, one strobe -> data_out=1000, clip=0, valid_out exactly 12 cycles after the strobe and one cycle wide.
- Weighted sum: band i = 100*i, all gains 32 (0.5) -> data_out=2250. Then band0 = -1 only, gain0=32 -> data_out=-1 (floor), clip=0.
- Saturation: all bands=10000 with unity gain -> data_out=32767, clip=1. All bands=-10000 -> data_out=-32768, clip=1. Next strobe with all bands 0 -> data_out=0, clip=0.
- Overrun and input snapshot: strobe with band0=500, then a second strobe 5 cycles later, and band_data changed on the cycle after the first strobe -> overrun pulses once, data_out=500, and only one valid_out pulse occurs.
- Back-to-back: a second strobe in the same cycle as valid_out is accepted -> no overrun, and a second valid_out follows 12 cycles later with the correct value.
- Reset mid-mix: assert rst during cycle 4 of MAC -> the next cycle shows all outputs 0 and busy=0, no valid_out is produced for the aborted mix, and the following strobe produces a correct result.
